i2c_reg_slave: RTL and testbench
================================

I2C_REG_SLAVE -- requirements
Module: i2c_reg_slave

Interface
REQ-001 SHALL have parameter ADDR, default 7'h4F, meaning the 7-bit I2C target address; the R/W bit is not part of the match.
REQ-002 SHALL have parameter NUM_REGS, default 4, range 1..256, meaning the number of 8-bit registers in the bank.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port SCL, input, 1 bit: the I2C clock line, asynchronous to clk.
REQ-006 SHALL have port SDA_in, input, 1 bit: the sensed I2C data line, asynchronous to clk.
REQ-007 SHALL have port SDA_oe, output, 1 bit: 1 = pull SDA low; the block never drives SDA high (open-drain).
REQ-008 SHALL have port reg_out, output, NUM_REGS*8 bits: the register bank, reg i at bits [8i+7:8i].
REQ-009 SHALL have port wr_strobe, output, 1 bit: one-clk pulse when a register is written.
REQ-010 SHALL have port wr_index, output, 8 bits: the index written, valid with wr_strobe.
REQ-011 SHALL have port busy, output, 1 bit: 1 from this target's address ACK until STOP or repeated START.

Function
REQ-012 SCL and SDA_in SHALL each pass a 2-flop synchronizer; edges are detected on the synchronized values; clk ≥ 10x SCL.
REQ-013 START SHALL be detected as an SDA fall while SCL = 1; STOP as an SDA rise while SCL = 1; both take effect in any state.
REQ-014 Data SHALL be sampled on the SCL rising edge, MSB first; SDA_oe SHALL change only on the clk following the SCL falling-edge detect.
REQ-015 States SHALL be IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-016 IDLE -> ADDR on START; any state -> ADDR on repeated START; any state -> IDLE on STOP.
REQ-017 ADDR: shift 8 bits; on the 8th bit, if bits[7:1] != ADDR -> IGNORE with SDA_oe = 0; else -> ADDR_ACK and latch R/W = bit0.
REQ-018 ADDR_ACK: SDA_oe = 1 for the 9th clock; next state is PTR if W, or RDATA if R.
REQ-019 PTR: the 8-bit byte is the register pointer; if < NUM_REGS -> PTR_ACK and load ptr; else -> IGNORE with NACK (SDA_oe = 0).
REQ-020 WDATA: after 8 bits, reg[ptr] <= byte; wr_strobe = 1 for exactly one clk; wr_index = ptr; -> WDATA_ACK (ACK); then ptr increments, wrapping NUM_REGS-1 -> 0, and -> WDATA.
REQ-021 RDATA: drive reg[ptr] MSB first (SDA_oe = ~bit) from the SCL fall after the ACK; then -> RDATA_ACK with SDA_oe = 0.
REQ-022 RDATA_ACK: master ACK (SDA = 0 at SCL rise) -> ptr increments with wrap -> RDATA; master NACK -> IGNORE.
REQ-023 Read pointer SHALL persist from the last write transaction; its reset value is 0.
REQ-024 IGNORE: SDA_oe = 0 and no register updates until START or STOP.
REQ-025 A STOP or START mid-byte SHALL discard the partial byte; no register write occurs.

Reset
REQ-026 While reset = 1 at a clk edge, the block SHALL enter IDLE; SDA_oe, wr_strobe, busy, wr_index, ptr, the bit counter and all of reg_out SHALL be 0; synchronizer flops SHALL be 1.
REQ-027 Reset asserted mid-transaction SHALL release SDA on the next clk; the block SHALL then ignore the bus until a fresh START.

Verification
REQ-028 START, 0x9E, 0x01, 0xA5, STOP -> ACK ×3; reg_out[15:8] = 0xA5; one wr_strobe with wr_index = 1.
REQ-029 Write pointer 0x03 then data 0x11, 0x22 (NUM_REGS = 4) -> reg3 = 0x11, reg0 = 0x22 (wrap); 2 strobes.
REQ-030 Preload reg1 = 0x5A, reg2 = 0xC3: START 0x9E 0x01, repeated START 0x9F, read 2 bytes (ACK then NACK) -> bytes 0x5A then 0xC3; SDA released after the NACK.
REQ-031 START 0x90 -> NACK; SDA_oe = 0 for the whole transfer; no reg_out change; busy = 0.
REQ-032 Pointer 0x04 with NUM_REGS = 4 -> pointer NACKed; subsequent data ignored.
REQ-033 STOP after 4 data bits, or reset during a data byte -> no write; SDA_oe = 0; the next full transaction succeeds.

Source files
------------

// File: rtl/i2c_reg_slave.sv
// I2C target with a small 8-bit register bank: write a pointer byte, then stream data
// writes or reads with auto-increment. The whole design runs on clk; SCL/SDA are oversampled.
module i2c_reg_slave #(
  parameter logic [6:0] ADDR     = 7'h4F,
  parameter int         NUM_REGS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SCL,
  input  logic                  SDA_in,
  output logic                  SDA_oe,
  output logic [NUM_REGS*8-1:0] reg_out,
  output logic                  wr_strobe,
  output logic [7:0]            wr_index,
  output logic                  busy
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
    ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK, ST_IGNORE
  } state_e;

  logic [1:0] scl_sync_q, sda_sync_q, arm_q;
  logic       scl_prev_q, sda_prev_q;
  logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  state_e                   state_q, state_d;
  logic [3:0]               bit_cnt_q, bit_cnt_d;
  logic [6:0]               sh_q, sh_d, tx_q, tx_d;
  logic [7:0]               ptr_q, ptr_d, widx_q, widx_d;
  logic                     rw_q, rw_d, oe_q, oe_d, busy_q, busy_d, wstb_q, wstb_d;
  logic [NUM_REGS-1:0][7:0] regs_q, regs_d;
  logic [7:0]               byte_in, rd_byte, ptr_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      arm_q      <= 2'b00;
    end else begin
      scl_sync_q <= {scl_sync_q[0], SCL};
      sda_sync_q <= {sda_sync_q[0], SDA_in};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
      arm_q      <= {arm_q[0], 1'b1};
    end
  end

  // Edges are masked until the synchronizers have flushed their reset value, so a bus
  // sitting at SCL=1/SDA=0 when reset drops is not mistaken for a START.
  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = arm_q[1] &  scl_s & ~scl_prev_q;
  assign scl_fall  = arm_q[1] & ~scl_s &  scl_prev_q;
  assign start_det = arm_q[1] & scl_s & scl_prev_q &  sda_prev_q & ~sda_s;
  assign stop_det  = arm_q[1] & scl_s & scl_prev_q & ~sda_prev_q &  sda_s;

  assign byte_in = {sh_q, sda_s};
  assign ptr_inc = (ptr_q == 8'(NUM_REGS - 1)) ? 8'd0 : ptr_q + 8'd1;

  always_comb begin
    rd_byte = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (ptr_q == 8'(i)) rd_byte = regs_q[i];
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    widx_d    = widx_q;
    rw_d      = rw_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    wstb_d    = 1'b0;
    regs_d    = regs_q;
    if (stop_det || start_det) begin
      state_d   = stop_det ? ST_IDLE : ST_ADDR;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: if (scl_rise) begin
          sh_d      = byte_in[6:0];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            if (state_q == ST_ADDR) begin
              if (byte_in[7:1] == ADDR) begin
                state_d = ST_ADDR_ACK;
                rw_d    = byte_in[0];
                busy_d  = 1'b1;
              end else begin
                state_d = ST_IGNORE;
              end
            end else if (state_q == ST_PTR) begin
              if ({1'b0, byte_in} < 9'(NUM_REGS)) begin
                state_d = ST_PTR_ACK;
                ptr_d   = byte_in;
              end else begin
                state_d = ST_IGNORE;
              end
            end else begin
              state_d = ST_WDATA_ACK;
              wstb_d  = 1'b1;
              widx_d  = ptr_q;
              for (int i = 0; i < NUM_REGS; i++)
                if (ptr_q == 8'(i)) regs_d[i] = byte_in;
            end
          end
        end
        // First SCL fall after the byte pulls SDA low; the next one ends the ACK clock.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
          if (!oe_q) begin
            oe_d = 1'b1;
          end else if (state_q == ST_ADDR_ACK && rw_q) begin
            state_d = ST_RDATA;
            tx_d    = rd_byte[6:0];
            oe_d    = ~rd_byte[7];
          end else begin
            oe_d    = 1'b0;
            state_d = ST_WDATA;
            if (state_q == ST_ADDR_ACK) state_d = ST_PTR;
            if (state_q == ST_WDATA_ACK) ptr_d = ptr_inc;
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d   = ST_RDATA_ACK;
              bit_cnt_d = '0;
              oe_d      = 1'b0;
            end else begin
              oe_d = ~tx_q[6];
              tx_d = {tx_q[5:0], 1'b0};
            end
          end
        end
        // Reaching the fall here implies the master ACKed at the preceding rise.
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_s) state_d = ST_IGNORE;
            else       ptr_d   = ptr_inc;
          end else if (scl_fall) begin
            state_d = ST_RDATA;
            tx_d    = rd_byte[6:0];
            oe_d    = ~rd_byte[7];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      tx_q      <= '0;
      ptr_q     <= '0;
      widx_q    <= '0;
      rw_q      <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      wstb_q    <= 1'b0;
      regs_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      tx_q      <= tx_d;
      ptr_q     <= ptr_d;
      widx_q    <= widx_d;
      rw_q      <= rw_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      wstb_q    <= wstb_d;
      regs_q    <= regs_d;
    end
  end

  assign SDA_oe    = oe_q;
  assign reg_out   = regs_q;
  assign wr_strobe = wstb_q;
  assign wr_index  = widx_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed bench: bit-banged I2C master against i2c_reg_slave (ADDR 0x4F, 4 registers).
module tb_i2c_reg_slave;
  localparam int Q = 10;  // quarter SCL period in clk cycles

  logic        clk = 1'b0, reset = 1'b1, scl_m = 1'b1, sda_m = 1'b1;
  wire         sda_bus;
  logic        SDA_oe, wr_strobe, busy;
  logic [31:0] reg_out;
  logic [7:0]  wr_index;
  int          n_chk = 0, n_fail = 0, stb_cnt = 0, oe_cnt = 0, busy_cnt = 0;
  logic [7:0]  last_idx = 8'h00;

  assign sda_bus = sda_m & ~SDA_oe;
  always #5 clk = ~clk;

  i2c_reg_slave #(.ADDR(7'h4F), .NUM_REGS(4)) dut (
    .clk(clk), .reset(reset), .SCL(scl_m), .SDA_in(sda_bus), .SDA_oe(SDA_oe),
    .reg_out(reg_out), .wr_strobe(wr_strobe), .wr_index(wr_index), .busy(busy)
  );

  always @(negedge clk) begin
    if (wr_strobe) begin
      stb_cnt++;
      last_idx = wr_index;
    end
    if (SDA_oe) oe_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic write_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sda_m = b[7-i]; tick(Q);
      scl_m = 1'b1;   tick(2*Q);
      scl_m = 1'b0;   tick(Q);
    end
  endtask

  task automatic ack_phase(output logic ack);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    ack = ~sda_bus; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    write_bits(b, 8);
    ack_phase(ack);
  endtask

  task automatic read_byte(input logic m_ack, output logic [7:0] b);
    b = '0;
    for (int i = 0; i < 8; i++) begin
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b1; tick(Q);
      b = {b[6:0], sda_bus}; tick(Q);
      scl_m = 1'b0; tick(Q);
    end
    sda_m = ~m_ack; tick(Q);
    scl_m = 1'b1;   tick(2*Q);
    scl_m = 1'b0;   tick(Q);
    sda_m = 1'b1;
  endtask

  initial begin
    logic        a;
    logic [7:0]  rb;
    int          s0, o0, b0;
    logic [31:0] snap;

    tick(4);
    chk("rst_oe", SDA_oe, 0);
    chk("rst_stb", wr_strobe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_widx", wr_index, 0);
    chk("rst_regs", reg_out, 0);
    reset = 1'b0;
    tick(4);

    // single write: pointer 1, data A5
    s0 = stb_cnt;
    i2c_start();
    write_byte(8'h9E, a); chk("w1_addr_ack", a, 1);
    chk("w1_busy", busy, 1);
    write_byte(8'h01, a); chk("w1_ptr_ack", a, 1);
    write_byte(8'hA5, a); chk("w1_data_ack", a, 1);
    i2c_stop();
    chk("w1_reg1", reg_out[15:8], 8'hA5);
    chk("w1_regs", reg_out, 32'h0000A500);
    chk("w1_nstb", stb_cnt - s0, 1);
    chk("w1_idx", last_idx, 1);
    chk("w1_busy_stop", busy, 0);

    // pointer wrap 3 -> 0
    s0 = stb_cnt;
    i2c_start();
    write_byte(8'h9E, a);
    write_byte(8'h03, a);
    write_byte(8'h11, a); chk("w2_d0_ack", a, 1);
    write_byte(8'h22, a); chk("w2_d1_ack", a, 1);
    i2c_stop();
    chk("w2_regs", reg_out, 32'h1100A522);
    chk("w2_nstb", stb_cnt - s0, 2);
    chk("w2_idx", last_idx, 0);

    // preload reg1/reg2, then read back through a repeated START
    i2c_start();
    write_byte(8'h9E, a);
    write_byte(8'h01, a);
    write_byte(8'h5A, a);
    write_byte(8'hC3, a);
    i2c_stop();
    chk("pre_regs", reg_out, 32'h11C35A22);
    s0 = stb_cnt;
    i2c_start();
    write_byte(8'h9E, a);
    write_byte(8'h01, a); chk("rd_ptr_ack", a, 1);
    i2c_start();
    write_byte(8'h9F, a); chk("rd_addr_ack", a, 1);
    read_byte(1'b1, rb); chk("rd_byte0", rb, 8'h5A);
    read_byte(1'b0, rb); chk("rd_byte1", rb, 8'hC3);
    tick(4);
    chk("rd_release", SDA_oe, 0);
    i2c_stop();
    chk("rd_nstb", stb_cnt - s0, 0);

    // wrong address: never ACKs, never busy
    s0 = stb_cnt; o0 = oe_cnt; b0 = busy_cnt; snap = reg_out;
    i2c_start();
    write_byte(8'h90, a); chk("na_addr_ack", a, 0);
    write_byte(8'h01, a); chk("na_b1_ack", a, 0);
    write_byte(8'h77, a);
    i2c_stop();
    chk("na_oe_cycles", oe_cnt - o0, 0);
    chk("na_busy_cycles", busy_cnt - b0, 0);
    chk("na_regs", reg_out, snap);
    chk("na_nstb", stb_cnt - s0, 0);

    // pointer out of range
    s0 = stb_cnt;
    i2c_start();
    write_byte(8'h9E, a);
    write_byte(8'h04, a); chk("bp_ptr_ack", a, 0);
    write_byte(8'h55, a); chk("bp_data_ack", a, 0);
    i2c_stop();
    chk("bp_regs", reg_out, snap);
    chk("bp_nstb", stb_cnt - s0, 0);

    // STOP after 4 data bits, then a full write
    s0 = stb_cnt;
    i2c_start();
    write_byte(8'h9E, a);
    write_byte(8'h00, a);
    write_bits(8'hA0, 4);
    i2c_stop();
    chk("ps_regs", reg_out, snap);
    chk("ps_nstb", stb_cnt - s0, 0);
    chk("ps_oe", SDA_oe, 0);
    i2c_start();
    write_byte(8'h9E, a);
    write_byte(8'h00, a);
    write_byte(8'h77, a); chk("ps_full_ack", a, 1);
    i2c_stop();
    chk("ps_full_regs", reg_out, 32'h11C35A77);

    // reset inside a data byte
    i2c_start();
    write_byte(8'h9E, a);
    write_byte(8'h02, a);
    write_bits(8'hF0, 3);
    reset = 1'b1; tick(2); reset = 1'b0;
    chk("rw_oe", SDA_oe, 0);
    chk("rw_busy", busy, 0);
    chk("rw_regs", reg_out, 0);
    s0 = stb_cnt;
    write_bits(8'h00, 5);
    ack_phase(a); chk("rw_ignored_ack", a, 0);
    i2c_stop();
    chk("rw_nstb", stb_cnt - s0, 0);
    i2c_start();
    write_byte(8'h9E, a);
    write_byte(8'h02, a);
    write_byte(8'h3C, a); chk("rw_full_ack", a, 1);
    i2c_stop();
    chk("rw_full_regs", reg_out, 32'h003C0000);
    chk("rw_full_idx", last_idx, 2);

    // reset while the target drives a read bit low
    i2c_start();
    write_byte(8'h9E, a);
    write_byte(8'h00, a);
    i2c_start();
    write_byte(8'h9F, a);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(2*Q);
    scl_m = 1'b0; tick(Q);
    chk("rr_driving", SDA_oe, 1);
    reset = 1'b1; tick(1); reset = 1'b0;
    chk("rr_release", SDA_oe, 0);
    i2c_stop();
    s0 = stb_cnt;
    i2c_start();
    write_byte(8'h9E, a);
    write_byte(8'h01, a);
    write_byte(8'hC7, a); chk("rr_full_ack", a, 1);
    i2c_stop();
    chk("rr_full_regs", reg_out, 32'h0000C700);
    chk("rr_nstb", stb_cnt - s0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
